// File: rtl/sizes.sv
// Shared data widths and the psum type for the PE and its collector.
package sizes;

  localparam int DATA_SIZE        = 8;
  localparam int BIGGER_DATA_SIZE = 16;

  typedef logic signed [BIGGER_DATA_SIZE-1:0] psum_t;

  localparam psum_t PSUM_MAX = {1'b0, {(BIGGER_DATA_SIZE-1){1'b1}}};
  localparam psum_t PSUM_MIN = {1'b1, {(BIGGER_DATA_SIZE-1){1'b0}}};

endpackage

// File: rtl/psum_fifo.sv
// First-word fall-through result FIFO; head reads as zero when empty.
module psum_fifo
  import sizes::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  flush_i,
  input  logic  push_i,
  input  logic  pop_i,
  input  psum_t data_i,
  output psum_t data_o,
  output logic  full_o,
  output logic  empty_o
);

  localparam int AW = $clog2(DEPTH);

  psum_t         mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          push_ok;
  logic          pop_ok;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign data_o  = empty_o ? '0 : mem_q[rd_q];

  // A push into a full FIFO is fine when the head leaves in the same cycle.
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_ok) wr_d = wr_q + AW'(1);
      if (pop_ok)  rd_d = rd_q + AW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   cnt_d = cnt_q + (AW+1)'(1);
        2'b01:   cnt_d = cnt_q - (AW+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush_i) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/psum_collector.sv
// Channel-reduction collector: accumulates, saturates and queues PE psums.
// Define PSUM_COLLECTOR_RELU_EN to clamp negative results to zero.
module psum_collector
  import sizes::*;
#(
  parameter int MAX_ACC    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               clear_i,
  input  logic [$clog2(MAX_ACC+1)-1:0]       num_acc_i,
  input  logic signed [BIGGER_DATA_SIZE-1:0] psum_i,
  input  logic                               psum_valid_i,
  output logic signed [BIGGER_DATA_SIZE-1:0] out_data_o,
  output logic                               out_valid_o,
  input  logic                               out_ready_i,
  output logic                               full_o,
  output logic                               busy_o,
  output logic                               overflow_o
);

  localparam int CW    = $clog2(MAX_ACC+1);
  localparam int ACC_W = BIGGER_DATA_SIZE + $clog2(MAX_ACC);
  localparam int GW    = ACC_W - BIGGER_DATA_SIZE;

  typedef logic signed [ACC_W-1:0] acc_t;

  function automatic acc_t sx(input psum_t v);
    return {{GW{v[BIGGER_DATA_SIZE-1]}}, v};
  endfunction

  function automatic psum_t sat(input acc_t s);
    if (s > sx(PSUM_MAX))      return PSUM_MAX;
    else if (s < sx(PSUM_MIN)) return PSUM_MIN;
    else                       return s[BIGGER_DATA_SIZE-1:0];
  endfunction

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] tgt_q, tgt_d;
  acc_t          acc_q, acc_d;
  logic          ov_q, ov_d;
  logic [CW-1:0] n_req;
  logic [CW-1:0] tgt_eff;
  logic          last;
  acc_t          sum;
  psum_t         sat_v;
  psum_t         res;
  logic          push;
  logic          pop;
  logic          f_full;
  logic          f_empty;

  // Targets above MAX_ACC would outgrow the accumulator guard bits.
  always_comb begin
    n_req = num_acc_i;
    if (num_acc_i == '0)                n_req = CW'(1);
    else if (num_acc_i > CW'(MAX_ACC)) n_req = CW'(MAX_ACC);
  end

  assign tgt_eff = (cnt_q == '0) ? n_req : tgt_q;
  assign last    = (cnt_q == tgt_eff - CW'(1));
  assign sum     = (cnt_q == '0) ? sx(psum_i) : acc_q + sx(psum_i);
  assign sat_v   = sat(sum);

`ifdef PSUM_COLLECTOR_RELU_EN
  assign res = sat_v[BIGGER_DATA_SIZE-1] ? '0 : sat_v;
`else
  assign res = sat_v;
`endif

  assign push = psum_valid_i & last & ~clear_i;
  assign pop  = out_valid_o & out_ready_i;

  always_comb begin
    cnt_d = cnt_q;
    tgt_d = tgt_q;
    acc_d = acc_q;
    ov_d  = ov_q;
    if (clear_i) begin
      cnt_d = '0;
      acc_d = '0;
      ov_d  = 1'b0;
    end else if (psum_valid_i) begin
      tgt_d = tgt_eff;
      if (last) begin
        cnt_d = '0;
        acc_d = '0;
        ov_d  = ov_q | (f_full & ~pop);
      end else begin
        cnt_d = cnt_q + CW'(1);
        acc_d = sum;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      tgt_q <= '0;
      acc_q <= '0;
      ov_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tgt_q <= tgt_d;
      acc_q <= acc_d;
      ov_q  <= ov_d;
    end
  end

  psum_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush_i(clear_i),
    .push_i (push),
    .pop_i  (pop),
    .data_i (res),
    .data_o (out_data_o),
    .full_o (f_full),
    .empty_o(f_empty)
  );

  assign out_valid_o = ~f_empty;
  assign full_o      = f_full;
  assign busy_o      = (cnt_q != '0);
  assign overflow_o  = ov_q;

endmodule

// File: doc/psum_collector.md
Name: psum_collector

Overview:
- Downstream neighbour of the PE. Consumes the PE's partial-sum stream (psum_o / psum_valid_o).
- Accumulates a runtime-configured number of partial sums per output pixel (channel reduction) and saturates the total to psum width.
- Buffers finished results in a small FIFO. Results leave on a valid/ready port towards the output memory writer.

Parameters:
- MAX_ACC, 16, maximum partial sums per group; sizes accumulator guard bits and counter.
- FIFO_DEPTH, 4, result FIFO entries; power of two, at least 2.

Ports:
- clk  input  1  sole clock.
- rst_n  input  1  asynchronous active-low reset.
- clear_i  input  1  synchronous flush of group state, FIFO and overflow flag.
- num_acc_i  input  $clog2(MAX_ACC+1)  partial sums per group; 0 is treated as 1.
- psum_i  input  BIGGER_DATA_SIZE  signed partial sum; driven from the PE's psum_o.
- psum_valid_i  input  1  partial-sum strobe; driven from the PE's psum_valid_o.
- out_data_o  output  BIGGER_DATA_SIZE  signed finished result (FIFO head).
- out_valid_o  output  1  FIFO not empty.
- out_ready_i  input  1  consumer accepts the head this cycle.
- full_o  output  1  FIFO full; the array controller pauses PEs while this is high.
- busy_o  output  1  group in progress (count != 0).
- overflow_o  output  1  sticky: a finished result was dropped.

Behaviour:
- Reset: count=0, acc=0, FIFO empty. out_valid_o=0, out_data_o=0, full_o=0, busy_o=0, overflow_o=0.
- Accumulator width ACC_W = BIGGER_DATA_SIZE + $clog2(MAX_ACC). Every addition is sign-extended; the accumulator never wraps.
- num_acc_i is latched into the group target when a psum arrives with count==0. Changes mid-group are ignored.
- psum arrives with count < target-1:
  - count==0: acc <= psum.
  - otherwise: acc <= acc + psum.
  - Then count++.
- psum arrives with count == target-1 (final psum):
  - result = sat(acc + psum); with target==1, result = sat(psum).
  - sat clamps to [-2^(B-1), 2^(B-1)-1], where B = BIGGER_DATA_SIZE.
  - Result is pushed into the FIFO; count <= 0.
- Latency: result is visible on out_data_o with out_valid_o=1 in the cycle after the final psum, if the FIFO was empty.
- FIFO is first-word fall-through. A pop occurs when out_valid_o && out_ready_i.
- Push while full:
  - With a pop in the same cycle: push is accepted and occupancy is unchanged.
  - Without a pop: result is dropped, overflow_o <= 1, and the group still completes (count <= 0).
- Pop when empty: no effect.
- full_o and out_valid_o are derived from registered occupancy.
- clear_i has priority over everything in its cycle. It sets count=0, acc=0, empties the FIFO and sets overflow_o=0. A psum arriving in the same cycle is discarded.
- rst_n assertion mid-group or mid-drain returns all state to reset values immediately. Nothing partial is retained.
- busy_o = (count != 0).

Optional Feature:
- Macro PSUM_COLLECTOR_RELU_EN.
- Defined: the saturated result is passed through ReLU (negative becomes 0) before the FIFO push.
- Undefined: the signed saturated result is stored unchanged.
- Accumulation itself is identical either way.

Decomposition:
- Package sizes holds:
  - DATA_SIZE and BIGGER_DATA_SIZE;
  - typedef psum_t, a signed BIGGER_DATA_SIZE-bit value;
  - constants PSUM_MAX and PSUM_MIN used by the saturation.
- One sub-module: psum_fifo, a parameterised FWFT FIFO with push, pop, full, empty and a data port of psum_t.
- Accumulate, count and saturate logic stays in psum_collector.

Test Plan:
- Basic group: num_acc_i=3, psums 100, -30, 7 on consecutive cycles, out_ready_i=1 -> out_valid_o=1 with out_data_o=77 one cycle after the 7; busy_o is 1 during the group.
- Saturation: num_acc_i=2, psums 30000 then 10000 -> 32767. Psums -30000 then -10000 -> -32768. Without RELU_EN, -5 alone (num_acc_i=1) -> -5; with RELU_EN -> 0.
- FIFO full and overflow: FIFO_DEPTH=4, num_acc_i=1, out_ready_i=0, psums 1..5:
  - full_o=1 after the 4th psum; overflow_o=1 after the 5th;
  - raising out_ready_i drains 1, 2, 3, 4 in order.
- Push while full with pop: FIFO full of 1..4, out_ready_i=1 and a final psum 9 in the same cycle -> full_o stays 1, and the subsequent drain is 2, 3, 4, 9.
- Clear mid-group: num_acc_i=3, psums 50, 50, then clear_i with psum 50 in the same cycle, then psums 1, 1, 1 -> single output 3; overflow_o=0.
- num_acc_i=0 and reset mid-group: num_acc_i=0 with psum 42 -> output 42 (treated as 1). rst_n pulsed after 1 of 3 psums, then 4, 5, 6 -> output 15.
